// File: rtl/lif_neuron_array.sv
// Leaky integrate-and-fire neuron stage fed by the MAC array.
// Each lane integrates a valid current into an unsigned membrane potential, leaks by
// pot >> leakShift on tick, fires a one-cycle registered spike when a valid input brings
// the potential to threshold, then ignores input for REFRAC_CYCLES cycles.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   currents   - packed unsigned currents, lane i at [i*IN_WIDTH +: IN_WIDTH]
//   inValids   - per-lane current valid
//   tick       - timestep strobe, applies the leak on this edge
//   threshold  - shared firing threshold
//   leakShift  - leak shift amount, 0 disables the leak
//   spikes     - registered one-cycle spike pulse per lane
//   potentials - registered membrane potentials, lane i at [i*POT_WIDTH +: POT_WIDTH]
//   spikeCount - saturating count of all spikes since reset
module lif_neuron_array #(
   parameter int unsigned NUM_NEURONS   = 8,
   parameter int unsigned IN_WIDTH      = 16,
   parameter int unsigned POT_WIDTH     = 20,
   parameter int unsigned REFRAC_CYCLES = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_NEURONS*IN_WIDTH-1:0]  currents,
   input  logic [NUM_NEURONS-1:0]           inValids,
   input  logic                             tick,
   input  logic [POT_WIDTH-1:0]             threshold,
   input  logic [3:0]                       leakShift,
   output logic [NUM_NEURONS-1:0]           spikes,
   output logic [NUM_NEURONS*POT_WIDTH-1:0] potentials,
   output logic [15:0]                      spikeCount
);

   typedef enum logic [0:0] {StIntegrate, StRefractory} lane_state_e;

   localparam int unsigned SumWidth = POT_WIDTH + 1;
   localparam int unsigned PopWidth = $clog2(NUM_NEURONS + 1);
   // Counter is loaded with REFRAC_CYCLES-1 so exactly REFRAC_CYCLES inputs are dropped.
   localparam logic [3:0] RefracInit = (REFRAC_CYCLES == 0) ? 4'd0 : 4'(REFRAC_CYCLES - 1);

   logic [NUM_NEURONS-1:0] spike_d;

   for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
      lane_state_e            state_q, state_d;
      logic [3:0]             cnt_q, cnt_d;
      logic [POT_WIDTH-1:0]   pot_q, pot_d;
      logic [POT_WIDTH-1:0]   leaked;
      logic [SumWidth-1:0]    sum;
      logic [POT_WIDTH-1:0]   sat;
      logic [IN_WIDTH-1:0]    cur;
      logic                   spike_n;
      logic                   spike_q;

      assign cur = currents[i*IN_WIDTH +: IN_WIDTH];

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         pot_d   = pot_q;
         spike_n = 1'b0;
         leaked  = pot_q;
         if (tick && leakShift != 4'd0) begin
            leaked = pot_q - (pot_q >> leakShift);
         end
         // Leak first, then add the current, one bit wider to catch overflow.
         sum = {1'b0, leaked} + (inValids[i] ? SumWidth'(cur) : '0);
         sat = sum[POT_WIDTH] ? '1 : sum[POT_WIDTH-1:0];

         unique case (state_q)
            StIntegrate: begin
               // Only a valid input can fire; leak-only cycles never do.
               if (inValids[i] && sat >= threshold) begin
                  spike_n = 1'b1;
                  pot_d   = '0;
                  if (REFRAC_CYCLES != 0) begin
                     state_d = StRefractory;
                     cnt_d   = RefracInit;
                  end
               end else begin
                  pot_d = sat;
               end
            end
            StRefractory: begin
               pot_d = '0;
               if (cnt_q == 4'd0) begin
                  state_d = StIntegrate;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            default: begin
               state_d = StIntegrate;
               pot_d   = '0;
            end
         endcase
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= StIntegrate;
            cnt_q   <= 4'd0;
            pot_q   <= '0;
            spike_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pot_q   <= pot_d;
            spike_q <= spike_n;
         end
      end

      assign spike_d[i]                              = spike_n;
      assign spikes[i]                               = spike_q;
      assign potentials[i*POT_WIDTH +: POT_WIDTH]    = pot_q;
   end

   logic [PopWidth-1:0] pop;
   logic [16:0]         count_sum;
   logic [15:0]         count_q, count_d;

   // Count the spikes being registered on this edge so spikeCount tracks spikes.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         pop = pop + PopWidth'(spike_d[i]);
      end
      count_sum = {1'b0, count_q} + 17'(pop);
      count_d   = count_sum[16] ? 16'hFFFF : count_sum[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign spikeCount = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: hand-derived vector table, directed corner
// sequences and randomized stimulus against a behavioural lane model.
module tb_lif_neuron_array;
   localparam int N  = 8;
   localparam int IW = 16;
   localparam int PW = 20;
   localparam int RC = 2;
   localparam int CW = N * PW;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*IW-1:0] currents;
   logic [N-1:0]    inValids;
   logic            tick;
   logic [PW-1:0]   threshold;
   logic [3:0]      leakShift;
   logic [N-1:0]    spikes;
   logic [N*PW-1:0] potentials;
   logic [15:0]     spikeCount;

   lif_neuron_array #(
      .NUM_NEURONS  (N),
      .IN_WIDTH     (IW),
      .POT_WIDTH    (PW),
      .REFRAC_CYCLES(RC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .currents  (currents),
      .inValids  (inValids),
      .tick      (tick),
      .threshold (threshold),
      .leakShift (leakShift),
      .spikes    (spikes),
      .potentials(potentials),
      .spikeCount(spikeCount)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: potential per lane, number of inputs still to drop, spike total.
   int           m_pot[N];
   int           m_ref[N];
   int           m_cnt;
   logic [N-1:0] m_spk;

   typedef struct {
      logic [IW-1:0] cur;
      logic [N-1:0]  val;
      logic          tk;
      logic [PW-1:0] thr;
      logic [3:0]    ls;
      logic [N-1:0]  e_spk;
      logic [PW-1:0] e_pot;
      logic [15:0]   e_cnt;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_pot[i] = 0;
         m_ref[i] = 0;
      end
      m_cnt = 0;
      m_spk = '0;
   endtask

   task automatic model_step();
      int pop;
      int cur;
      int leaked;
      int sum;
      pop = 0;
      for (int i = 0; i < N; i++) begin
         m_spk[i] = 1'b0;
         cur = int'(currents[i*IW +: IW]);
         if (m_ref[i] > 0) begin
            m_ref[i]--;
            m_pot[i] = 0;
         end else begin
            leaked = m_pot[i];
            if (tick && leakShift != 0) leaked = m_pot[i] - (m_pot[i] >> leakShift);
            sum = leaked + (inValids[i] ? cur : 0);
            if (sum > 'hFFFFF) sum = 'hFFFFF;
            if (inValids[i] && sum >= int'(threshold)) begin
               m_spk[i] = 1'b1;
               m_pot[i] = 0;
               m_ref[i] = RC;
               pop++;
            end else begin
               m_pot[i] = sum;
            end
         end
      end
      m_cnt = (m_cnt + pop > 65535) ? 65535 : m_cnt + pop;
   endtask

   function automatic logic [CW-1:0] m_pots();
      logic [CW-1:0] r;
      for (int i = 0; i < N; i++) r[i*PW +: PW] = PW'(m_pot[i]);
      return r;
   endfunction

   // One clock edge with the currently driven inputs, compared against the model.
   task automatic step();
      @(posedge clk);
      #1;
      model_step();
      check("spikes", CW'(spikes), CW'(m_spk));
      check("potentials", potentials, m_pots());
      check("spikeCount", CW'(spikeCount), CW'(m_cnt));
   endtask

   // Assert reset between edges; outputs must clear before any edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check("reset_spikes", CW'(spikes), '0);
      check("reset_potentials", potentials, '0);
      check("reset_spikeCount", CW'(spikeCount), '0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle_inputs();
      currents  = '0;
      inValids  = '0;
      tick      = 1'b0;
      threshold = '0;
      leakShift = '0;
   endtask

   initial begin
      int sat_cycles;
      reset = 1'b0;
      idle_inputs();

      tbl[0]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'h00, 20'd32, 16'd0};
      tbl[1]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'h00, 20'd64, 16'd0};
      tbl[2]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'h00, 20'd96, 16'd0};
      tbl[3]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'hFF, 20'd0,  16'd8};
      tbl[4]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'h00, 20'd0,  16'd8};
      tbl[5]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'h00, 20'd0,  16'd8};
      tbl[6]  = '{16'h20, 8'hFF, 1'b0, 20'd100,  4'd0, 8'h00, 20'd32, 16'd8};
      tbl[7]  = '{16'h20, 8'hFF, 1'b0, 20'd1000, 4'd0, 8'h00, 20'd64, 16'd8};
      tbl[8]  = '{16'h00, 8'h00, 1'b1, 20'd1000, 4'd1, 8'h00, 20'd32, 16'd8};
      tbl[9]  = '{16'h0A, 8'hFF, 1'b1, 20'd1000, 4'd1, 8'h00, 20'd26, 16'd8};
      tbl[10] = '{16'h00, 8'h00, 1'b1, 20'd1000, 4'd0, 8'h00, 20'd26, 16'd8};

      #2;
      do_reset();

      // Integrate, fire, refractory drop, leak and leak-plus-current.
      for (int r = 0; r < 11; r++) begin
         currents  = {N{tbl[r].cur}};
         inValids  = tbl[r].val;
         tick      = tbl[r].tk;
         threshold = tbl[r].thr;
         leakShift = tbl[r].ls;
         step();
         check($sformatf("tbl%0d_spikes", r), CW'(spikes), CW'(tbl[r].e_spk));
         check($sformatf("tbl%0d_pot", r), potentials, {N{tbl[r].e_pot}});
         check($sformatf("tbl%0d_cnt", r), CW'(spikeCount), CW'(tbl[r].e_cnt));
      end

      // Saturation: 16 inputs reach 0xFFFF0, the 17th clamps to threshold and fires.
      idle_inputs();
      do_reset();
      threshold = 20'hFFFFF;
      currents  = {N{16'hFFFF}};
      inValids  = '1;
      repeat (16) step();
      check("sat_pot16", potentials, {N{20'hFFFF0}});
      check("sat_spk16", CW'(spikes), '0);
      step();
      check("sat_spk17", CW'(spikes), CW'(8'hFF));
      check("sat_pot17", potentials, '0);

      // Valid gating with threshold 0.
      idle_inputs();
      do_reset();
      currents = {N{16'h0003}};
      inValids = 8'h05;
      step();
      check("gate_spk", CW'(spikes), CW'(8'h05));
      inValids = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("gate_idle_spk", CW'(spikes), '0);
      end

      // Async reset right after a spike, mid-refractory.
      idle_inputs();
      do_reset();
      threshold = 20'd50;
      for (int i = 0; i < N; i++) currents[i*IW +: IW] = (i == 0) ? 16'd100 : 16'd10;
      inValids = '1;
      step();
      check("pre_reset_spk", CW'(spikes), CW'(8'h01));
      #2;
      do_reset();
      threshold = 20'd1000;
      currents  = {N{16'h0020}};
      inValids  = 8'h01;
      step();
      check("post_reset_pot0", CW'(potentials[PW-1:0]), CW'(20'd32));

      // Randomized traffic against the model.
      idle_inputs();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            currents[i*IW +: IW] = ($urandom_range(0, 3) == 0) ? IW'($urandom)
                                                                : IW'($urandom_range(0, 400));
         end
         inValids  = N'($urandom);
         tick      = ($urandom_range(0, 3) == 0);
         threshold = ($urandom_range(0, 9) == 0) ? PW'(0) : PW'($urandom_range(0, 1500));
         leakShift = 4'($urandom);
         step();
      end

      // spikeCount saturation: every lane fires as often as refractory allows.
      idle_inputs();
      do_reset();
      inValids   = '1;
      sat_cycles = 0;
      for (int c = 0; c < 30000 && sat_cycles < 20; c++) begin
         step();
         if (m_cnt == 65535) sat_cycles++;
      end
      check("count_saturated", CW'(spikeCount), CW'(16'hFFFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Leaky integrate-and-fire neuron stage directly downstream of the MAC array. Each lane takes one 16-bit MAC result plus its valid bit as an input current. The lane integrates the current into a membrane potential, applies a shift-based leak on each timestep tick, and emits a one-cycle spike when the potential reaches threshold. After a spike the lane is refractory for a fixed number of cycles. Spikes feed the downstream spike router/encoder.

Parameters:
NUM_NEURONS, 8, number of lanes; matches the MAC count.
IN_WIDTH, 16, width of each input current; matches the MAC output width.
POT_WIDTH, 20, membrane potential width, unsigned.
REFRAC_CYCLES, 2, clock cycles a lane ignores input and leak after a spike; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
currents  input  NUM_NEURONS*IN_WIDTH  packed unsigned currents; lane i occupies bits [i*IN_WIDTH +: IN_WIDTH].
inValids  input  NUM_NEURONS  per-lane current valid.
tick  input  1  timestep strobe; applies the leak this cycle.
threshold  input  POT_WIDTH  firing threshold, shared by all lanes; sampled every cycle.
leakShift  input  4  leak amount: pot minus (pot >> leakShift); a value of 0 disables the leak.
spikes  output  NUM_NEURONS  one-cycle spike pulse per lane, registered.
potentials  output  NUM_NEURONS*POT_WIDTH  registered membrane potentials, for debug and readback.
spikeCount  output  16  saturating total of spikes emitted since reset.

Behaviour:
- Reset (asynchronous, active-high):
  - potentials = 0, spikes = 0, spikeCount = 0.
  - All lanes go to INTEGRATE; refractory counters = 0.
  - Asserting reset mid-refractory or mid-spike clears all of this immediately.
- Per-lane state machine: INTEGRATE and REFRACTORY.
- INTEGRATE, evaluated each rising edge:
  - leaked = tick ? pot - (pot >> leakShift) : pot. When leakShift = 0, leaked = pot.
  - sum = leaked + (inValids[i] ? current_i : 0), computed at POT_WIDTH+1 bits. If it exceeds 2^POT_WIDTH - 1, it saturates to 2^POT_WIDTH - 1.
  - Fire condition: inValids[i] = 1 AND sum >= threshold.
    - Lanes with no valid input never fire, even when threshold = 0.
    - Leak-only cycles never fire.
  - On fire: spikes[i] <= 1 and pot <= 0. If REFRAC_CYCLES > 0, go to REFRACTORY with counter = REFRAC_CYCLES - 1. If REFRAC_CYCLES = 0, stay in INTEGRATE.
  - Otherwise: pot <= sum, spikes[i] <= 0.
- REFRACTORY:
  - pot is held at 0; inputs and ticks are dropped; spikes[i] <= 0.
  - Counter decrements each cycle. In the cycle it reads 0, the lane returns to INTEGRATE, and the next cycle's input is integrated.
  - Net effect: exactly REFRAC_CYCLES input cycles are ignored after the spike edge.
- Latency: one cycle. An input sampled on edge N is reflected in potentials/spikes after edge N; spikes is high for exactly the cycle following edge N.
- spikes is a pulse. Back-to-back spikes on one lane are possible only when REFRAC_CYCLES = 0.
- spikeCount: on each edge, adds the popcount of the spike vector being registered, saturating at 0xFFFF.
- threshold and leakShift are combinational inputs. A change takes effect on the very next edge.
- Lanes are fully independent. A simultaneous tick and valid applies leak first, then adds the current.
- There is no backpressure: every valid input is consumed or, in REFRACTORY, dropped.

Test Plan:
1. Integrate/fire, threshold = 100, all lanes valid with current 0x0020 every cycle, tick = 0:
   - potentials go 32, 64, 96.
   - 4th valid edge: sum 128 >= 100, so spikes = 0xFF for one cycle, potentials = 0, spikeCount = 8.
2. Refractory, REFRAC_CYCLES = 2, continuing scenario 1:
   - The next 2 valid inputs are dropped (pot stays 0).
   - The 3rd input after the spike gives pot = 32.
   - spikes = 0x00 throughout.
3. Leak and simultaneous events, lane 0, pot = 64, leakShift = 1, threshold = 1000:
   - tick alone: pot becomes 32.
   - Then tick with valid current 10 on the same edge: 32 - 16 + 10 = 26. No spike.
4. Saturation, threshold = 0xFFFFF, current 0xFFFF every cycle:
   - After 16 inputs pot = 0xFFFF0 and there is no spike.
   - 17th input saturates pot to 0xFFFFF, which equals threshold, so the lane fires and pot = 0.
5. Valid gating, threshold = 0, inValids = 0x05 for one cycle:
   - spikes = 0x05 exactly once.
   - Idle cycles with threshold = 0 produce no spikes.
6. Async reset mid-refractory: assert reset between clock edges right after a spike.
   - potentials, spikes and spikeCount read 0 immediately, before the next edge.
   - After release, the first valid input integrates normally.
